// File: rtl/audioport_pkg.sv
// audioport_pkg: shared constants and types for the audioport sample path.
//   AUDIO_CHANNELS   - default channel count of the sample FIFO
//   AUDIO_FIFO_SIZE  - default per-channel FIFO depth (power of two)
//   AUDIO_FIFO_PRIME - default per-channel fill level needed to start output
//   audio_sample_t   - one 24-bit audio sample
//   fifo_state_t     - FIFO output state machine encoding
package audioport_pkg;

  localparam int unsigned AUDIO_CHANNELS   = 2;
  localparam int unsigned AUDIO_FIFO_SIZE  = 16;
  localparam int unsigned AUDIO_FIFO_PRIME = AUDIO_FIFO_SIZE / 2;

  typedef logic [23:0] audio_sample_t;

  typedef enum logic {
    PRIMING = 1'b0,
    RUN     = 1'b1
  } fifo_state_t;

endpackage

// File: rtl/sample_ring_fifo.sv
// sample_ring_fifo: single-channel ring buffer.
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clr        - flush (pointers and level back to zero)
//   push/wdata - append a sample; accepted if not full or popped this cycle
//   pop        - remove the head sample; ignored when empty
//   rdata      - current head sample (valid when not empty)
//   level      - fill count, 0..DEPTH
//   full/empty - derived from the registered level only
module sample_ring_fifo #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rd_ptr];

  // A full channel still accepts a push when its head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage is deliberately not reset; stale entries are never visible
  // because the pointers and level are.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/audio_sample_fifo_mc.sv
// audio_sample_fifo_mc: multi-channel audio sample buffer between the bus
// write path and the DSP tick. One ring buffer per channel; pushes go to one
// channel at a time, pops happen on all channels together on each tick.
// A PRIMING/RUN state machine holds the output at zero until every channel
// has PRIME samples, and returns to PRIMING after an underflow.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   wr_en/wr_ch/wr_data - push a sample into channel wr_ch (out of range: ignored)
//   clr         - flush all channels, back to PRIMING, sticky flags kept
//   status_clr  - clear overflow/underflow
//   tick_in     - DSP sample strobe
//   audio_out   - channel k at [k*DATA_W +: DATA_W]
//   tick_out    - tick_in delayed one cycle, marks audio_out valid
//   level/full/empty - per-channel fill state
//   running     - state machine in RUN
//   overflow/underflow - sticky error flags
// Build option: AUDIO_FIFO_HOLD_LAST_EN - on a RUN underflow audio_out keeps
// its previous value instead of going to zero.
module audio_sample_fifo_mc
  import audioport_pkg::*;
#(
  parameter int unsigned CHANNELS = AUDIO_CHANNELS,
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned DEPTH    = AUDIO_FIFO_SIZE,
  parameter int unsigned PRIME    = DEPTH / 2
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                wr_en,
  input  logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] wr_ch,
  input  logic [DATA_W-1:0]                   wr_data,
  input  logic                                clr,
  input  logic                                status_clr,
  input  logic                                tick_in,
  output logic [CHANNELS*DATA_W-1:0]          audio_out,
  output logic                                tick_out,
  output logic [CHANNELS*$clog2(DEPTH+1)-1:0] level,
  output logic [CHANNELS-1:0]                 full,
  output logic [CHANNELS-1:0]                 empty,
  output logic                                running,
  output logic                                overflow,
  output logic                                underflow
);

  localparam int unsigned CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned LW = $clog2(DEPTH+1);

  fifo_state_t                state;
  logic [CHANNELS-1:0]        ch_push;
  logic [LW-1:0]              ch_level [CHANNELS];
  logic [DATA_W-1:0]          ch_rdata [CHANNELS];
  logic [CHANNELS*DATA_W-1:0] rdata_bus;
  logic                       all_primed;
  logic                       all_ready;
  logic                       pop_all;
  logic                       ovf_evt;
  logic                       uf_evt;

  assign running = (state == RUN);

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    sample_ring_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (clr),
      .push  (ch_push[k]),
      .pop   (pop_all),
      .wdata (wr_data),
      .rdata (ch_rdata[k]),
      .level (ch_level[k]),
      .full  (full[k]),
      .empty (empty[k])
    );
    assign level[k*LW +: LW]         = ch_level[k];
    assign rdata_bus[k*DATA_W +: DATA_W] = ch_rdata[k];
  end

  // An out-of-range wr_ch matches no channel index, so the push is dropped
  // without any flag.
  always_comb begin
    ch_push    = '0;
    all_primed = 1'b1;
    all_ready  = 1'b1;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      ch_push[k] = wr_en && (wr_ch == CW'(k));
      if (ch_level[k] < LW'(PRIME)) all_primed = 1'b0;
      if (empty[k])                 all_ready  = 1'b0;
    end
  end

  always_comb begin
    pop_all = tick_in && ((state == PRIMING) ? all_primed : all_ready);
    uf_evt  = tick_in && (state == RUN) && !all_ready;
    ovf_evt = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (ch_push[k] && full[k] && !pop_all) ovf_evt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= PRIMING;
      audio_out <= '0;
      tick_out  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      state     <= PRIMING;
      audio_out <= '0;
      tick_out  <= 1'b0;
    end else begin
      tick_out <= tick_in;

      // A new event wins over status_clr in the same cycle.
      if (ovf_evt)         overflow <= 1'b1;
      else if (status_clr) overflow <= 1'b0;
      if (uf_evt)          underflow <= 1'b1;
      else if (status_clr) underflow <= 1'b0;

      if (tick_in) begin
        case (state)
          PRIMING: begin
            if (all_primed) begin
              audio_out <= rdata_bus;
              state     <= RUN;
            end else begin
              audio_out <= '0;
            end
          end
          RUN: begin
            if (all_ready) begin
              audio_out <= rdata_bus;
            end else begin
`ifdef AUDIO_FIFO_HOLD_LAST_EN
              audio_out <= audio_out;
`else
              audio_out <= '0;
`endif
              state <= PRIMING;
            end
          end
          default: state <= PRIMING;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_sample_fifo_mc.sv
module tb_audio_sample_fifo_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // DUT A: default configuration (2 channels, depth 16, prime 8)
  logic        rst_a, wr_en_a, clr_a, status_clr_a, tick_in_a;
  logic        wr_ch_a;
  logic [23:0] wr_data_a;
  logic [47:0] audio_out_a;
  logic        tick_out_a, running_a, overflow_a, underflow_a;
  logic [9:0]  level_a;
  logic [1:0]  full_a, empty_a;

  audio_sample_fifo_mc dut_a (
    .clk(clk), .rst(rst_a), .wr_en(wr_en_a), .wr_ch(wr_ch_a), .wr_data(wr_data_a),
    .clr(clr_a), .status_clr(status_clr_a), .tick_in(tick_in_a),
    .audio_out(audio_out_a), .tick_out(tick_out_a), .level(level_a),
    .full(full_a), .empty(empty_a), .running(running_a),
    .overflow(overflow_a), .underflow(underflow_a)
  );

  // DUT B: 4 channels, depth 4, prime 1 (pointer wrap stress)
  logic        rst_b, wr_en_b, clr_b, status_clr_b, tick_in_b;
  logic [1:0]  wr_ch_b;
  logic [23:0] wr_data_b;
  logic [95:0] audio_out_b;
  logic        tick_out_b, running_b, overflow_b, underflow_b;
  logic [11:0] level_b;
  logic [3:0]  full_b, empty_b;

  audio_sample_fifo_mc #(.CHANNELS(4), .DATA_W(24), .DEPTH(4), .PRIME(1)) dut_b (
    .clk(clk), .rst(rst_b), .wr_en(wr_en_b), .wr_ch(wr_ch_b), .wr_data(wr_data_b),
    .clr(clr_b), .status_clr(status_clr_b), .tick_in(tick_in_b),
    .audio_out(audio_out_b), .tick_out(tick_out_b), .level(level_b),
    .full(full_b), .empty(empty_b), .running(running_b),
    .overflow(overflow_b), .underflow(underflow_b)
  );

  logic [47:0] exp_a [$];
  logic [95:0] exp_b [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every tick_out must match the next queued expectation.
  always @(negedge clk) begin
    if (tick_out_a) begin
      if (exp_a.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL audio_a: unexpected tick_out, audio_out %h expected none", audio_out_a);
      end else check("audio_a", audio_out_a, exp_a.pop_front());
    end
    if (tick_out_b) begin
      if (exp_b.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL audio_b: unexpected tick_out, audio_out %h expected none", audio_out_b);
      end else check("audio_b", audio_out_b, exp_b.pop_front());
    end
  end

  function automatic logic [23:0] smp(input logic [7:0] base, input int i);
    return {base, 16'(i)};
  endfunction

  function automatic logic [4:0] lvl_a(input int k);
    return level_a[k*5 +: 5];
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_a(input int ch, input logic [23:0] d);
    wr_en_a = 1'b1; wr_ch_a = 1'(ch); wr_data_a = d;
    step();
    wr_en_a = 1'b0;
  endtask

  task automatic tick_a(input logic [47:0] e);
    tick_in_a = 1'b1; exp_a.push_back(e);
    step();
    tick_in_a = 1'b0;
  endtask

  task automatic push_b(input int ch, input logic [23:0] d);
    wr_en_b = 1'b1; wr_ch_b = 2'(ch); wr_data_b = d;
    step();
    wr_en_b = 1'b0;
  endtask

  task automatic tick_b(input logic [95:0] e);
    tick_in_b = 1'b1; exp_b.push_back(e);
    step();
    tick_in_b = 1'b0;
  endtask

  logic [47:0] uf_exp;
  logic [95:0] eb;

  initial begin
    rst_a = 1'b1; wr_en_a = 1'b0; wr_ch_a = 1'b0; wr_data_a = '0;
    clr_a = 1'b0; status_clr_a = 1'b0; tick_in_a = 1'b0;
    rst_b = 1'b1; wr_en_b = 1'b0; wr_ch_b = '0; wr_data_b = '0;
    clr_b = 1'b0; status_clr_b = 1'b0; tick_in_b = 1'b0;
    step(); step();
    rst_a = 1'b0;

    // Reset state
    check("rst_audio", audio_out_a, 48'h0);
    check("rst_tick_out", tick_out_a, 1'b0);
    check("rst_level", level_a, 10'h0);
    check("rst_empty", empty_a, 2'b11);
    check("rst_full", full_a, 2'b00);
    check("rst_running", running_a, 1'b0);
    check("rst_flags", {overflow_a, underflow_a}, 2'b00);

    // Priming: 7 per channel is not enough
    for (int i = 0; i < 7; i++) begin
      push_a(0, smp(8'hA0, i));
      push_a(1, smp(8'hB0, i));
    end
    tick_a(48'h0);
    check("prime_running_0", running_a, 1'b0);
    check("prime_level_7", level_a, {5'd7, 5'd7});
    push_a(0, smp(8'hA0, 7));
    push_a(1, smp(8'hB0, 7));
    tick_a({smp(8'hB0, 0), smp(8'hA0, 0)});
    check("prime_running_1", running_a, 1'b1);
    check("prime_level_after", level_a, {5'd7, 5'd7});
    check("prime_underflow", underflow_a, 1'b0);

    // Underflow: ch0 drains while ch1 keeps 3
    for (int i = 8; i < 11; i++) push_a(1, smp(8'hB0, i));
    for (int i = 1; i < 8; i++) tick_a({smp(8'hB0, i), smp(8'hA0, i)});
    check("uf_pre_level", level_a, {5'd3, 5'd0});
`ifdef AUDIO_FIFO_HOLD_LAST_EN
    uf_exp = {smp(8'hB0, 7), smp(8'hA0, 7)};
`else
    uf_exp = 48'h0;
`endif
    tick_a(uf_exp);
    check("uf_flag", underflow_a, 1'b1);
    check("uf_running", running_a, 1'b0);
    check("uf_level_ch1", lvl_a(1), 5'd3);

    // Flush keeps sticky underflow
    clr_a = 1'b1; step(); clr_a = 1'b0;
    check("clr_level", level_a, 10'h0);
    check("clr_keeps_uf", underflow_a, 1'b1);

    // Overflow: 17 pushes to ch1
    for (int i = 0; i < 17; i++) push_a(1, smp(8'hC0, i));
    check("ovf_level", lvl_a(1), 5'd16);
    check("ovf_full", full_a, 2'b10);
    check("ovf_empty", empty_a, 2'b01);
    check("ovf_flag", overflow_a, 1'b1);
    status_clr_a = 1'b1; step(); status_clr_a = 1'b0;
    check("status_clr_flags", {overflow_a, underflow_a}, 2'b00);

    // Contents of ch1 are C0..C15 in order
    for (int i = 0; i < 8; i++) push_a(0, smp(8'hD0, i));
    tick_a({smp(8'hC0, 0), smp(8'hD0, 0)});
    for (int i = 1; i < 16; i++) begin
      push_a(0, smp(8'hD0, 7 + i));
      tick_a({smp(8'hC0, i), smp(8'hD0, i)});
    end
    check("drain_level", level_a, {5'd0, 5'd7});
    check("drain_running", running_a, 1'b1);

    // Full channel pushed and popped in the same cycle
    for (int i = 23; i < 32; i++) push_a(0, smp(8'hD0, i));
    push_a(1, smp(8'hE0, 0));
    push_a(1, smp(8'hE0, 1));
    check("full_ch0", full_a, 2'b01);
    wr_en_a = 1'b1; wr_ch_a = 1'b0; wr_data_a = smp(8'hD0, 32);
    tick_in_a = 1'b1; exp_a.push_back({smp(8'hE0, 0), smp(8'hD0, 16)});
    step();
    wr_en_a = 1'b0; tick_in_a = 1'b0;
    check("fullpop_level", lvl_a(0), 5'd16);
    check("fullpop_no_ovf", overflow_a, 1'b0);

    // Overflow then flush with push and tick in the same cycle
    push_a(0, smp(8'hD0, 33));
    check("ovf2_flag", overflow_a, 1'b1);
    clr_a = 1'b1; wr_en_a = 1'b1; wr_ch_a = 1'b1; wr_data_a = 24'hFFFFFF; tick_in_a = 1'b1;
    step();
    clr_a = 1'b0; wr_en_a = 1'b0; tick_in_a = 1'b0;
    check("flush_level", level_a, 10'h0);
    check("flush_audio", audio_out_a, 48'h0);
    check("flush_running", running_a, 1'b0);
    check("flush_tick_out", tick_out_a, 1'b0);
    check("flush_flags", {overflow_a, underflow_a}, 2'b10);
    rst_a = 1'b1; step(); rst_a = 1'b0;
    check("rst2_flags", {overflow_a, underflow_a}, 2'b00);
    check("rst2_empty", empty_a, 2'b11);
    check("rst2_audio", audio_out_a, 48'h0);

    // status_clr coinciding with a new overflow: flag stays set
    for (int i = 0; i < 16; i++) push_a(0, smp(8'hF0, i));
    wr_en_a = 1'b1; wr_ch_a = 1'b0; wr_data_a = smp(8'hF0, 16); status_clr_a = 1'b1;
    step();
    wr_en_a = 1'b0; status_clr_a = 1'b0;
    check("sclr_vs_ovf", overflow_a, 1'b1);

    // Wrap-around on DUT B: 40 ramp samples per channel, 2 samples ahead
    rst_b = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 4; c++) push_b(c, smp(8'(c), i));
    for (int i = 0; i < 40; i++) begin
      if (i + 2 < 40)
        for (int c = 0; c < 4; c++) push_b(c, smp(8'(c), i + 2));
      eb = {smp(8'd3, i), smp(8'd2, i), smp(8'd1, i), smp(8'd0, i)};
      tick_b(eb);
    end
    check("wrap_level", level_b, 12'h0);
    check("wrap_flags", {overflow_b, underflow_b}, 2'b00);
    check("wrap_running", running_b, 1'b1);

    step(); step(); step();
    check("queue_a_drained", 128'(exp_a.size()), 128'd0);
    check("queue_b_drained", 128'(exp_b.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_sample_fifo_mc.md
# audio_sample_fifo_mc

Multi-channel audio sample buffer between the APB register write path and the DSP tick domain of the audioport. Each channel has its own ring buffer. Samples are pushed one at a time by the bus interface and popped in lockstep across all channels on each DSP tick. A priming state machine zeroes the output until every channel holds enough data, and again after an underflow. This generalises the two-channel fixed-depth left/right FIFO pair.

## Interface
- CHANNELS, 2: number of audio channels, 1..8
- DATA_W, 24: sample width in bits
- DEPTH, 16: entries per channel; power of two, at least 2
- PRIME, DEPTH/2: per-channel fill level required to leave PRIMING, 1..DEPTH
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- wr_en  in  1  push request
- wr_ch  in  $clog2(CHANNELS) (min 1)  target channel of the push
- wr_data  in  DATA_W  sample to push
- clr  in  1  flush all channels and return to PRIMING; sticky flags are kept
- status_clr  in  1  clear the overflow and underflow sticky flags
- tick_in  in  1  one-cycle DSP sample strobe
- audio_out  out  CHANNELS*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- tick_out  out  1  tick_in delayed by one cycle; marks audio_out valid
- level  out  CHANNELS*$clog2(DEPTH+1)  per-channel fill count
- full, empty  out  CHANNELS  per-channel flags
- running  out  1  1 when the FSM is in RUN
- overflow, underflow  out  1  sticky error flags

## Operation
- FSM states: PRIMING (reset state) and RUN.
- **Push:** on wr_en, wr_data is appended to channel wr_ch.
  - If wr_ch ≥ CHANNELS, the push is ignored and no flag is set.
  - A push to a full channel with no simultaneous pop of that channel is dropped and sets overflow.
- **PRIMING:** on tick_in, if every level ≥ PRIME, pop one sample from every channel, load them into audio_out, and go to RUN. Otherwise audio_out becomes all zeros, nothing is popped, and underflow is not set.
- **RUN:** on tick_in, if every channel is non-empty, pop all channels and load audio_out. If any channel is empty:
  - no channel is popped;
  - underflow is set;
  - audio_out takes the underflow value (see Configuration);
  - the FSM returns to PRIMING.
- **Simultaneous push and pop on the same channel:** both happen and the level is unchanged. A push to a full channel is accepted if that channel is popped in the same cycle.
- **Pointers:** $clog2(DEPTH) bits, wrap modulo DEPTH. level is $clog2(DEPTH+1) bits, so DEPTH itself is representable.
- **Priority:** rst > clr > status_clr ≈ push/pop.
  - clr in the same cycle as a push or tick: the flush wins and the push is discarded.
  - status_clr and a new error event in the same cycle: the flag ends up set.
- **Reset values:** audio_out 0, tick_out 0, level 0, empty all 1, full all 0, running 0, overflow 0, underflow 0; FSM in PRIMING. Buffer contents are not reset.
- **clr:** same effect as reset except that overflow and underflow keep their values.
- **Reset or clr mid-stream:** takes effect at the next edge. Samples already loaded into audio_out are zeroed.

## Timing
- tick_in at edge t: audio_out and tick_out update at edge t+1. tick_out is high for exactly one cycle and is produced in both states.
- A push registered at edge t is visible in level after t and can be popped by a tick_in sampled at edge t+1.
- full, empty, level and running are registered, or derived combinationally from registered pointers only. They never depend on wr_en or tick_in in the same cycle.
- Throughput: one push per cycle; one pop set per tick; back-to-back ticks are supported.

## Configuration
- AUDIO_FIFO_HOLD_LAST_EN defined: on a RUN underflow, audio_out keeps its previous value.
- Not defined: on a RUN underflow, audio_out is driven to all zeros.
- In either case PRIMING ticks output zeros.

## Structure
- audioport_pkg gains:
  - AUDIO_CHANNELS, AUDIO_FIFO_SIZE and AUDIO_FIFO_PRIME constants used as top-level defaults;
  - typedef audio_sample_t (logic [23:0]);
  - enum fifo_state_t {PRIMING, RUN}.
- Sub-module sample_ring_fifo: a single-channel ring buffer with push, pop, clr, rdata, level, full and empty. It is instantiated CHANNELS times in a generate loop. The top level holds the FSM, audio_out registers, tick delay and sticky flags.

## Test plan
- **Priming:** defaults. Push 7 samples per channel, then tick → audio_out 0, running 0, tick_out pulses one cycle later. Push an 8th sample per channel, then tick → audio_out = {ch1 first sample, ch0 first sample}, running 1, level 7.
- **Underflow:** from RUN, drain channel 0 while channel 1 still holds 3, then tick:
  - without the macro: audio_out 0;
  - with AUDIO_FIFO_HOLD_LAST_EN: audio_out holds its previous value;
  - in both cases underflow 1, running 0, channel 1 level still 3.
- **Overflow:** push 17 samples to channel 1 with no ticks → level 16, full[1] 1, overflow 1, channel 1 contents are the first 16 samples in order. Then status_clr → overflow 0.
- **Full and pop same cycle:** channel 0 full, in RUN. Push and tick in the same cycle → push accepted, level stays 16, no overflow.
- **Flush and reset priority:** mid-stream, assert clr together with a push and a tick → all levels 0, audio_out 0, PRIMING, sticky flags kept. Then assert rst → all outputs at their reset values, including the flags.
- **Wrap-around:** CHANNELS=4, DEPTH=4, PRIME=1. Stream 40 ramp samples per channel with interleaved pushes and ticks → outputs are in order with no loss across pointer wraps.
